// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and arbitration helpers for mem_req_arbiter.
//   chid_w()   : width needed to index n channels (at least 1 bit)
//   tag_t      : in-flight tag {chid, killed}; chid is sized for up to MAX_CH channels
//   arb_fixed(): lowest requesting channel index
//   arb_rr()   : lowest requesting index >= start, wrapping to the lowest overall
package mem_arb_pkg;

    localparam int MAX_CH     = 32;
    localparam int CHID_MAX_W = 5;

    typedef logic [CHID_MAX_W-1:0] chid_t;

    typedef struct packed {
        chid_t chid;
        logic  killed;
    } tag_t;

    function automatic int chid_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Scans downwards so the last hit is the lowest index; no early exit needed.
    function automatic int arb_fixed(input logic [MAX_CH-1:0] req);
        int win;
        win = 0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (req[i]) win = i;
        end
        return win;
    endfunction

    // First pass picks the wrap-around candidate, second pass overrides it with
    // the lowest requester at or above the start position when one exists.
    function automatic int arb_rr(input logic [MAX_CH-1:0] req, input int start);
        int win;
        win = 0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (req[i]) win = i;
        end
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (req[i] && (i >= start)) win = i;
        end
        return win;
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: in-order FIFO of in-flight request tags.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_tag   append a tag (caller guarantees not full)
//   pop              drop the head tag (caller guarantees not empty)
//   kill[DEPTH]      slot-indexed: set the killed flag of that slot in place
//   entries          full storage array, so the owner can scan/flush it
//   slot_valid       which storage slots currently hold live FIFO entries
//   head, empty, full
// DEPTH must be a power of two.
module tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  tag_t               push_tag,
    input  logic               pop,
    input  logic [DEPTH-1:0]   kill,
    output tag_t [DEPTH-1:0]   entries,
    output logic [DEPTH-1:0]   slot_valid,
    output tag_t               head,
    output logic               empty,
    output logic               full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Distance from the read pointer, wrapping modulo DEPTH.
    function automatic logic [PTR_W-1:0] ring_off(input logic [PTR_W-1:0] a,
                                                  input logic [PTR_W-1:0] b);
        return a - b;
    endfunction

    // NOTE: the tag array is reset along with the pointers so every killed flag
    // starts at 0; it is only DEPTH small entries, so this is cheap.
    // NOTE: all state here uses non-blocking assignments so the kill loop, the
    // push write and the pointer updates all see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill[i]) entries[i].killed <= 1'b1;
            end
            if (push) begin
                entries[wr_ptr] <= push_tag;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_comb begin
        empty = (count == '0);
        full  = (count == CNT_W'(DEPTH));
        head  = entries[rd_ptr];
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid[i] = CNT_W'(ring_off(PTR_W'(i), rd_ptr)) < count;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: merges NCH request channels onto one memory port and routes
// in-order responses back, with per-channel flush of in-flight requests.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   ch_req/ch_we/ch_addr/ch_wdata     per-channel request (addr/wdata packed NBITS each)
//   ch_flush                          discard all outstanding requests of a channel
//   ch_gnt, ch_rvalid                 one-hot accept / response strobes
//   ch_rdata, ch_busy                 shared response data, live-outstanding flags
//   mem_proc_req/mem_we/mem_addr/mem_wdata, mem_rdy   memory request side
//   mem_valid, mem_rdata              memory response side
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, no rotation pointer); otherwise round-robin.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int NCH       = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       ch_req,
    input  logic [NCH-1:0]       ch_we,
    input  logic [NCH*NBITS-1:0] ch_addr,
    input  logic [NCH*NBITS-1:0] ch_wdata,
    input  logic [NCH-1:0]       ch_flush,
    output logic [NCH-1:0]       ch_gnt,
    output logic [NCH-1:0]       ch_rvalid,
    output logic [NBITS-1:0]     ch_rdata,
    output logic [NCH-1:0]       ch_busy,
    output logic                 mem_proc_req,
    output logic                 mem_we,
    output logic [NBITS-1:0]     mem_addr,
    output logic [NBITS-1:0]     mem_wdata,
    input  logic                 mem_rdy,
    input  logic                 mem_valid,
    input  logic [NBITS-1:0]     mem_rdata
);

    localparam int CHID_W = chid_w(NCH);

    logic                  any_req;
    logic                  accept;
    logic                  push_kill;
    logic                  pop;
    logic                  head_flush;
    logic                  deliver;
    logic                  full;
    logic                  empty;
    logic [CHID_W-1:0]     win_id;
    tag_t                  push_tag;
    tag_t                  head;
    tag_t [MAX_OUTST-1:0]  entries;
    logic [MAX_OUTST-1:0]  slot_valid;
    logic [MAX_OUTST-1:0]  kill;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign win_id = CHID_W'(arb_fixed(MAX_CH'(ch_req)));
`else
    // Points at the channel after the last granted one; moves only on accept.
    logic [CHID_W-1:0] rr_ptr;

    assign win_id = CHID_W'(arb_rr(MAX_CH'(ch_req), int'(rr_ptr)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rr_ptr <= '0;
        else if (accept) rr_ptr <= (win_id == CHID_W'(NCH - 1)) ? '0 : win_id + 1'b1;
    end
`endif

    // Request side. Issue stops while the tag FIFO is full, even if a response
    // pops it in the same cycle.
    // NOTE: every output of this block gets a default before the loop so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        any_req      = |ch_req;
        mem_proc_req = any_req && !full;
        accept       = mem_proc_req && mem_rdy;
        ch_gnt       = '0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        push_kill    = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (win_id == CHID_W'(c)) begin
                ch_gnt[c] = accept;
                push_kill = ch_flush[c];   // flush also catches the tag pushed this cycle
                if (any_req) begin
                    mem_we    = ch_we[c];
                    mem_addr  = ch_addr[c*NBITS +: NBITS];
                    mem_wdata = ch_wdata[c*NBITS +: NBITS];
                end
            end
        end
        push_tag = '{chid: chid_t'(win_id), killed: push_kill};
    end

    // Response side: a response with no tag in flight is ignored. A head tag
    // that is killed, or whose channel flushes this very cycle, is swallowed.
    always_comb begin
        pop        = mem_valid && !empty;
        head_flush = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (head.chid == chid_t'(c)) head_flush = ch_flush[c];
        end
        deliver = pop && !head.killed && !head_flush;
        for (int c = 0; c < NCH; c++) begin
            ch_rvalid[c] = deliver && (head.chid == chid_t'(c));
        end
        ch_rdata = deliver ? mem_rdata : '0;
    end

    // Flush marks matching live slots; busy reflects live, unkilled tags.
    always_comb begin
        kill    = '0;
        ch_busy = '0;
        for (int s = 0; s < MAX_OUTST; s++) begin
            for (int c = 0; c < NCH; c++) begin
                if (entries[s].chid == chid_t'(c)) begin
                    kill[s]    = slot_valid[s] && ch_flush[c];
                    ch_busy[c] = ch_busy[c] | (slot_valid[s] && !entries[s].killed);
                end
            end
        end
    end

    tag_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .push_tag   (push_tag),
        .pop        (pop),
        .kill       (kill),
        .entries    (entries),
        .slot_valid (slot_valid),
        .head       (head),
        .empty      (empty),
        .full       (full)
    );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized + directed bench for mem_req_arbiter (NCH=2,
// MAX_OUTST=4). A queue-based model of outstanding requests predicts grants,
// busy flags and responses; expected responses go to a scoreboard that a
// separate monitor drains whenever the DUT presents (or should present) one.
module tb_mem_req_arbiter;

    localparam int NBITS     = 32;
    localparam int NCH       = 2;
    localparam int MAX_OUTST = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NCH-1:0]       ch_req = '0;
    logic [NCH-1:0]       ch_we = '0;
    logic [NCH*NBITS-1:0] ch_addr = '0;
    logic [NCH*NBITS-1:0] ch_wdata = '0;
    logic [NCH-1:0]       ch_flush = '0;
    logic [NCH-1:0]       ch_gnt;
    logic [NCH-1:0]       ch_rvalid;
    logic [NBITS-1:0]     ch_rdata;
    logic [NCH-1:0]       ch_busy;
    logic                 mem_proc_req;
    logic                 mem_we;
    logic [NBITS-1:0]     mem_addr;
    logic [NBITS-1:0]     mem_wdata;
    logic                 mem_rdy = 1'b0;
    logic                 mem_valid = 1'b0;
    logic [NBITS-1:0]     mem_rdata = '0;

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .NBITS     (NBITS),
        .NCH       (NCH),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ch_req       (ch_req),
        .ch_we        (ch_we),
        .ch_addr      (ch_addr),
        .ch_wdata     (ch_wdata),
        .ch_flush     (ch_flush),
        .ch_gnt       (ch_gnt),
        .ch_rvalid    (ch_rvalid),
        .ch_rdata     (ch_rdata),
        .ch_busy      (ch_busy),
        .mem_proc_req (mem_proc_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdy      (mem_rdy),
        .mem_valid    (mem_valid),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        int ch;
        bit killed;
    } ent_t;

    typedef struct {
        int               ch;
        logic [NBITS-1:0] data;
    } rsp_t;

    ent_t mq[$];      // model: outstanding requests in issue order
    rsp_t exp_q[$];   // scoreboard: responses the DUT must deliver
    int   rr_start = 0;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [NBITS-1:0] act,
                         input logic [NBITS-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick_winner(input logic [NCH-1:0] req);
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int c = 0; c < NCH; c++) if (req[c]) return c;
`else
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (rr_start + k) % NCH;
            if (req[c]) return c;
        end
`endif
        return 0;
    endfunction

    // One clock cycle: drive at negedge, check request side, queue the
    // expected response, then advance the model at the rising edge.
    task automatic cycle(input logic [NCH-1:0] req, input logic [NCH-1:0] flush,
                         input bit rdy, input bit valid, input logic [NBITS-1:0] rdata);
        logic [NCH-1:0]   we;
        logic [NBITS-1:0] addr [NCH];
        logic [NBITS-1:0] wdata [NCH];
        logic [NCH-1:0]   gnt_e;
        logic [NCH-1:0]   busy_e;
        bit               preq;
        bit               acc;
        int               w;
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            we[c]    = 1'($urandom_range(0, 1));
            addr[c]  = $urandom;
            wdata[c] = $urandom;
            ch_addr[c*NBITS +: NBITS]  = addr[c];
            ch_wdata[c*NBITS +: NBITS] = wdata[c];
        end
        ch_req    = req;
        ch_we     = we;
        ch_flush  = flush;
        mem_rdy   = rdy;
        mem_valid = valid;
        mem_rdata = rdata;
        #1;
        preq  = (req != '0) && (mq.size() < MAX_OUTST);
        w     = pick_winner(req);
        acc   = preq && rdy;
        gnt_e = '0;
        if (acc) gnt_e[w] = 1'b1;
        busy_e = '0;
        foreach (mq[i]) if (!mq[i].killed) busy_e[mq[i].ch] = 1'b1;
        check("mem_proc_req", mem_proc_req, preq);
        check("ch_gnt", ch_gnt, gnt_e);
        check("ch_busy", ch_busy, busy_e);
        if (req != '0) begin
            check("mem_addr", mem_addr, addr[w]);
            check("mem_wdata", mem_wdata, wdata[w]);
            check("mem_we", mem_we, we[w]);
        end else begin
            check("mem_addr_idle", mem_addr, '0);
            check("mem_wdata_idle", mem_wdata, '0);
            check("mem_we_idle", mem_we, '0);
        end
        if (valid && mq.size() > 0 && !mq[0].killed && !flush[mq[0].ch])
            exp_q.push_back('{mq[0].ch, rdata});
        @(posedge clk);
        if (valid && mq.size() > 0) void'(mq.pop_front());
        foreach (mq[i]) if (flush[mq[i].ch]) mq[i].killed = 1'b1;
        if (acc) begin
            mq.push_back('{w, flush[w]});
            rr_start = (w + 1) % NCH;
        end
    endtask

    task automatic drain();
        while (mq.size() > 0) cycle('0, '0, 1'b1, 1'b1, $urandom);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst       = 1'b1;
        ch_req    = '0;
        ch_flush  = '0;
        mem_rdy   = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = $urandom;
        #1;
        check("rst_mem_proc_req", mem_proc_req, '0);
        check("rst_ch_gnt", ch_gnt, '0);
        check("rst_ch_busy", ch_busy, '0);
        check("rst_ch_rvalid", ch_rvalid, '0);
        check("rst_ch_rdata", ch_rdata, '0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_mem_we", mem_we, '0);
        mq.delete();
        rr_start = 0;
        @(negedge clk);
        rst       = 1'b0;
        mem_valid = 1'b0;
    endtask

    // Response monitor, sampled after the driver has settled the cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (ch_rvalid != '0 || exp_q.size() > 0) begin
                if (exp_q.size() == 0) begin
                    check("rvalid_spurious", ch_rvalid, '0);
                end else begin
                    rsp_t           e;
                    logic [NCH-1:0] oh;
                    e      = exp_q.pop_front();
                    oh     = '0;
                    oh[e.ch] = 1'b1;
                    check("ch_rvalid", ch_rvalid, oh);
                    check("ch_rdata", ch_rdata, e.data);
                end
            end else begin
                check("ch_rdata_idle", ch_rdata, '0);
            end
        end
    end

    initial begin
        reset_pulse();

        // Single read, response two cycles after the grant.
        cycle(2'b01, 2'b00, 1'b1, 1'b0, '0);
        cycle(2'b00, 2'b00, 1'b1, 1'b0, '0);
        cycle(2'b00, 2'b00, 1'b1, 1'b1, 32'hDEADBEEF);

        // Contention with responses returned each cycle.
        for (int i = 0; i < 4; i++) cycle(2'b11, 2'b00, 1'b1, mq.size() > 0, $urandom);
        drain();

        // Full: five back-to-back requests, then a pop while full.
        for (int i = 0; i < 5; i++) cycle(2'b01, 2'b00, 1'b1, 1'b0, '0);
        cycle(2'b01, 2'b00, 1'b1, 1'b1, $urandom);
        cycle(2'b01, 2'b00, 1'b1, 1'b0, '0);
        drain();

        // Flush three outstanding fetches; their responses vanish.
        for (int i = 0; i < 3; i++) cycle(2'b01, 2'b00, 1'b1, 1'b0, '0);
        cycle(2'b00, 2'b01, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle(2'b00, 2'b00, 1'b1, 1'b1, $urandom);
        cycle(2'b00, 2'b00, 1'b1, 1'b0, '0);

        // Flush coinciding with the pop of a channel-0 head, then a channel-1 response.
        cycle(2'b01, 2'b00, 1'b1, 1'b0, '0);
        cycle(2'b10, 2'b00, 1'b1, 1'b0, '0);
        cycle(2'b01, 2'b00, 1'b1, 1'b0, '0);
        cycle(2'b00, 2'b01, 1'b1, 1'b1, $urandom);
        cycle(2'b00, 2'b00, 1'b1, 1'b1, $urandom);
        cycle(2'b00, 2'b00, 1'b1, 1'b1, $urandom);

        // Randomized traffic, including stray responses on an empty FIFO.
        for (int i = 0; i < 400; i++) begin
            logic [NCH-1:0] fl;
            bit             v;
            for (int c = 0; c < NCH; c++) fl[c] = ($urandom_range(0, 9) == 0);
            v = (mq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            cycle(NCH'($urandom_range(0, 3)), fl, $urandom_range(0, 3) != 0, v, $urandom);
        end
        drain();

        // Reset with two requests in flight; a later response is ignored.
        cycle(2'b01, 2'b00, 1'b1, 1'b0, '0);
        cycle(2'b10, 2'b00, 1'b1, 1'b0, '0);
        reset_pulse();
        cycle(2'b00, 2'b00, 1'b1, 1'b1, $urandom);
        cycle(2'b00, 2'b00, 1'b1, 1'b0, '0);

        @(negedge clk);
        #3;
        check("scoreboard_left", exp_q.size(), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
